// File: rtl/serial_addsub_if.sv
// serial_addsub_if: start/done handshake, operands and results of the bit-serial adder/subtractor.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (output start, sub, a, b, input busy, done, result, cout, ovf);
    modport slave  (input start, sub, a, b, output busy, done, result, cout, ovf);
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: one full-adder cell iterated LSB-first over WIDTH cycles; subtract via ~b and carry-in 1.
// Define SERIAL_ADDSUB_OVF_EN to capture signed overflow; otherwise ovf is tied to 0.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    serial_addsub_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sum;
    logic             last_bit;

    assign sum      = a_q[0] ^ b_q[0] ^ carry_q;
    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && bus.start) begin
            a_d     = bus.a;
            b_d     = bus.b ^ {WIDTH{bus.sub}};
            carry_d = bus.sub;
            cnt_d   = '0;
            state_d = SHIFT;
        end else if (state_q == SHIFT) begin
            carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
            res_d   = {sum, res_q[WIDTH-1:1]};
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            state_d = last_bit ? DONE : SHIFT;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_q;
    // On the MSB iteration carry_q is the carry into the MSB and carry_d the carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else if (last_bit) ovf_q <= carry_q ^ carry_d;
    end
    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.busy   = (state_q == SHIFT);
    assign bus.done   = (state_q == DONE);
    assign bus.result = res_q;
    assign bus.cout   = carry_q;
endmodule
